// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sseg_pkg;

    typedef enum logic [0:0] {
        S_BLANK,
        S_DRIVE
    } scan_state_t;

    localparam logic [7:0] SSEG_OFF     = 8'hFF;
    localparam int         N_DIGITS_MAX = 8;

endpackage

// File: rtl/hex_to_sseg.sv
// Hex nibble to seven-segment decoder; output {dp,g..a}, active high.
module hex_to_sseg (
    input  logic [3:0] i_hex,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = 8'h00;
        o_seg[7] = i_dp;
        case (i_hex)
            4'h0: o_seg[6:0] = 7'h3F;
            4'h1: o_seg[6:0] = 7'h06;
            4'h2: o_seg[6:0] = 7'h5B;
            4'h3: o_seg[6:0] = 7'h4F;
            4'h4: o_seg[6:0] = 7'h66;
            4'h5: o_seg[6:0] = 7'h6D;
            4'h6: o_seg[6:0] = 7'h7D;
            4'h7: o_seg[6:0] = 7'h07;
            4'h8: o_seg[6:0] = 7'h7F;
            4'h9: o_seg[6:0] = 7'h6F;
            4'hA: o_seg[6:0] = 7'h77;
            4'hB: o_seg[6:0] = 7'h7C;
            4'hC: o_seg[6:0] = 7'h39;
            4'hD: o_seg[6:0] = 7'h5E;
            4'hE: o_seg[6:0] = 7'h79;
            default: o_seg[6:0] = 7'h71;
        endcase
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed common-anode 7-seg scanner with double-buffered image and blank gap.
// Optional SSEG_LZ_BLANK_EN: leading-zero suppression applied when an image is loaded.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*N_DIGITS-1:0]   hex_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blank_in,
    output logic [N_DIGITS-1:0]     an,
    output logic [7:0]              sseg,
    output logic                    frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam scan_state_t SLOT_START = (BLANK_CYCLES > 0) ? S_BLANK : S_DRIVE;

    logic [CNT_W-1:0]       r_cnt, w_cnt_next;
    logic [IDX_W-1:0]       r_idx, w_idx_next;
    scan_state_t            r_state, w_state_next;

    logic                   r_pend, w_pend_next;
    logic                   r_ready, r_tick;
    logic [4*N_DIGITS-1:0]  r_pend_hex, r_act_hex;
    logic [N_DIGITS-1:0]    r_pend_dp, r_act_dp;
    logic [N_DIGITS-1:0]    r_pend_blank, r_act_blank;
    logic [N_DIGITS-1:0]    r_an;
    logic [7:0]             r_sseg;

    logic                   w_slot_end, w_frame_end, w_accept, w_load;
    logic [N_DIGITS-1:0]    w_load_blank;
    logic [3:0]             w_sel_hex;
    logic                   w_sel_dp;
    logic [7:0]             w_dec_seg;
    logic [N_DIGITS-1:0]    w_an_drive;

    // Slot counter, digit index and scan state for the next cycle
    always_comb begin
        w_slot_end  = (r_cnt == CNT_W'(SCAN_DIV - 1));
        w_frame_end = w_slot_end && (r_idx == IDX_W'(N_DIGITS - 1));
        w_cnt_next  = w_slot_end ? '0 : r_cnt + 1'b1;
        w_idx_next  = r_idx;
        if (w_slot_end) begin
            w_idx_next = (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end
        w_state_next = (w_cnt_next < CNT_W'(BLANK_CYCLES)) ? S_BLANK : S_DRIVE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= SLOT_START;
        end else begin
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_state <= w_state_next;
        end
    end

    // Acceptance only happens while nothing is pending, so it never collides with a load
    always_comb begin
        w_accept    = upd_valid && r_ready;
        w_load      = w_frame_end && r_pend;
        w_pend_next = (r_pend && !w_load) || w_accept;
    end

`ifdef SSEG_LZ_BLANK_EN
    logic [N_DIGITS-1:0] w_lz_mask;

    always_comb begin
        logic v_run;
        w_lz_mask = '0;
        v_run     = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            v_run        = v_run && (r_pend_hex[4*i +: 4] == 4'h0) && !r_pend_dp[i];
            w_lz_mask[i] = v_run;
        end
    end

    assign w_load_blank = r_pend_blank | w_lz_mask;
`else
    assign w_load_blank = r_pend_blank;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend       <= 1'b0;
            r_ready      <= 1'b0;
            r_tick       <= 1'b0;
            r_pend_hex   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_act_hex    <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '1;
        end else begin
            r_pend  <= w_pend_next;
            r_ready <= !w_pend_next;
            r_tick  <= w_load;
            if (w_accept) begin
                r_pend_hex   <= hex_in;
                r_pend_dp    <= dp_in;
                r_pend_blank <= blank_in;
            end
            if (w_load) begin
                r_act_hex   <= r_pend_hex;
                r_act_dp    <= r_pend_dp;
                r_act_blank <= w_load_blank;
            end
        end
    end

    assign w_sel_hex  = r_act_hex[{r_idx, 2'b00} +: 4];
    assign w_sel_dp   = r_act_dp[r_idx];
    assign w_an_drive = ~(N_DIGITS'(1) << r_idx);

    hex_to_sseg u_dec (
        .i_hex (w_sel_hex),
        .i_dp  (w_sel_dp),
        .o_seg (w_dec_seg)
    );

    // Outputs lag the scan position by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an   <= '1;
            r_sseg <= SSEG_OFF;
        end else if (r_state == S_BLANK || r_act_blank[r_idx]) begin
            r_an   <= '1;
            r_sseg <= SSEG_OFF;
        end else begin
            r_an   <= w_an_drive;
            r_sseg <= ~w_dec_seg;
        end
    end

    assign upd_ready  = r_ready;
    assign frame_tick = r_tick;
    assign an         = r_an;
    assign sseg       = r_sseg;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: directed and random images against a cycle-position reference model.
module tb_sseg_scan_ctrl;

    localparam int N   = 4;
    localparam int DIV = 8;
    localparam int BLK = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            upd_valid = 1'b0;
    logic            upd_ready;
    logic [4*N-1:0]  hex_in = '0;
    logic [N-1:0]    dp_in = '0;
    logic [N-1:0]    blank_in = '0;
    logic [N-1:0]    an;
    logic [7:0]      sseg;
    logic            frame_tick;

    int checks = 0;
    int errors = 0;

    // Reference model: position in the scan is derived from the cycle number j since reset
    int              j;
    bit              m_pend;
    logic [4*N-1:0]  m_pend_hex, m_act_hex;
    logic [N-1:0]    m_pend_dp, m_act_dp, m_pend_blank, m_act_blank;
    logic [N-1:0]    exp_an;
    logic [7:0]      exp_sseg;
    logic            exp_tick;

    sseg_scan_ctrl #(
        .N_DIGITS     (N),
        .SCAN_DIV     (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .an         (an),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input logic [3:0] h);
        logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[h];
    endfunction

    function automatic logic [N-1:0] eff_blank(input logic [4*N-1:0] h, input logic [N-1:0] dp,
                                               input logic [N-1:0] bl);
        logic [N-1:0] r;
        r = bl;
`ifdef SSEG_LZ_BLANK_EN
        for (int i = N - 1; i >= 1; i--) begin
            if (h[4*i +: 4] == 4'h0 && !dp[i]) r[i] = 1'b1;
            else break;
        end
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, j, obs, exp);
        end
    endtask

    task automatic model_init();
        j           = 0;
        m_pend      = 1'b0;
        m_pend_hex  = '0;
        m_pend_dp   = '0;
        m_pend_blank = '0;
        m_act_hex   = '0;
        m_act_dp    = '0;
        m_act_blank = '1;
        exp_an      = '1;
        exp_sseg    = 8'hFF;
        exp_tick    = 1'b0;
    endtask

    // Check cycle j, advance the model across the clock edge, land #1 after it
    task automatic step(output bit acc);
        bit exp_ready;
        int s, d;
        exp_ready = (j >= 1) && !m_pend;
        check("an", 8'(an), 8'(exp_an));
        check("sseg", sseg, exp_sseg);
        check("frame_tick", 8'(frame_tick), 8'(exp_tick));
        check("upd_ready", 8'(upd_ready), 8'(exp_ready));
        acc = upd_valid && exp_ready;
        s = j % DIV;
        d = (j / DIV) % N;
        if (s < BLK || m_act_blank[d]) begin
            exp_an   = '1;
            exp_sseg = 8'hFF;
        end else begin
            exp_an   = ~(N'(1) << d);
            exp_sseg = ~{m_act_dp[d], seg7(m_act_hex[4*d +: 4])};
        end
        exp_tick = 1'b0;
        if (s == DIV - 1 && d == N - 1 && m_pend) begin
            m_act_hex   = m_pend_hex;
            m_act_dp    = m_pend_dp;
            m_act_blank = eff_blank(m_pend_hex, m_pend_dp, m_pend_blank);
            m_pend      = 1'b0;
            exp_tick    = 1'b1;
        end
        if (acc) begin
            m_pend       = 1'b1;
            m_pend_hex   = hex_in;
            m_pend_dp    = dp_in;
            m_pend_blank = blank_in;
        end
        @(posedge clk);
        #1;
        j++;
    endtask

    task automatic run(input int n);
        bit acc;
        for (int k = 0; k < n; k++) step(acc);
    endtask

    task automatic offer(input logic [4*N-1:0] h, input logic [N-1:0] dp, input logic [N-1:0] bl);
        bit acc;
        int budget;
        acc    = 1'b0;
        budget = 0;
        hex_in    = h;
        dp_in     = dp;
        blank_in  = bl;
        upd_valid = 1'b1;
        while (!acc && budget < 200) begin
            step(acc);
            budget++;
        end
        upd_valid = 1'b0;
        checks++;
        assert (acc === 1'b1) else begin
            errors++;
            $error("FAIL offer_timeout image=%h observed=not_accepted expected=accepted", h);
        end
        $display("offer image=%h dp=%b blank=%b accepted_at_cycle=%0d", h, dp, bl, j - 1);
    endtask

    task automatic do_reset(input int ncyc);
        reset     = 1'b1;
        upd_valid = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            #1;
            check("rst_an", 8'(an), 8'hF);
            check("rst_sseg", sseg, 8'hFF);
            check("rst_ready", 8'(upd_ready), 8'h0);
            check("rst_tick", 8'(frame_tick), 8'h0);
        end
        reset = 1'b0;
        model_init();
        $display("reset held %0d cycles", ncyc);
    endtask

    initial begin
        bit acc;
        model_init();

        // Reset, then a dark idle period with upd_ready raised
        do_reset(3);
        run(4);

        // Basic image; two frames cover every slot and its blank gap
        offer(16'h1234, 4'b0000, 4'b0000);
        run(2 * N * DIV);

        // Back-pressure: second image offered immediately, held until accepted
        offer(16'h1111, 4'b0000, 4'b0000);
        offer(16'h2222, 4'b0000, 4'b0000);
        run(2 * N * DIV);

        // Forced blank on digit 2
        offer(16'h8888, 4'b0000, 4'b0100);
        run(2 * N * DIV);

        // Leading zeros
        offer(16'h0050, 4'b0000, 4'b0000);
        run(2 * N * DIV);

        // Decimal points, including one that stops zero suppression
        offer(16'h00A0, 4'b0100, 4'b0000);
        run(2 * N * DIV);

        // Random valid/data stream
        for (int k = 0; k < 1500; k++) begin
            upd_valid = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                hex_in[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            end
            dp_in    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            blank_in = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
            step(acc);
            if (acc) $display("random accept image=%h dp=%b blank=%b cycle=%0d",
                              hex_in, dp_in, blank_in, j - 1);
        end
        upd_valid = 1'b0;
        run(N * DIV);

        // Reset mid-scan with an image pending: display must stay dark afterwards
        offer(16'h9876, 4'b1111, 4'b0000);
        run(13);
        do_reset(2);
        run(3 * N * DIV);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
